conv_window_gen_5x5: RTL
========================

Name: conv_window_gen_5x5

Overview:
- Streaming 5x5 sliding-window generator that produces the 25-pixel neighbourhood consumed by the directional Gabor convolution blocks (0°/45°/90°/135° kernels).
- Accepts one signed pixel per cycle in raster order and buffers four previous image rows in line buffers.
- Emits a registered 5x5 window for every valid-mode output position, with no padding, under a valid/ready handshake.

Parameters:
- pixel_width, 9, signed pixel width (matches pixel_int_width + pixel_dec_width of the convolution blocks).
- image_width, 516, pixels per row; must be ≥ 5.
- image_height, 516, rows per frame; must be ≥ 5.
- kernel_size, 5, window dimension; fixed at 5, and any other value is unsupported.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- pix_in  input  pixel_width  signed input pixel, raster order.
- pix_valid  input  1  pix_in valid.
- pix_sof  input  1  start of frame; qualifies the accepted pixel as (row 0, col 0).
- pix_ready  output  1  block can accept a pixel this cycle.
- win_out  output  25*pixel_width  window; slot k occupies bits [(k+1)*pixel_width-1 : k*pixel_width] and drives pixel(k+1) of the convolution block.
- win_valid  output  1  win_out holds a valid window.
- win_last  output  1  window is the final window of the frame.
- win_ready  input  1  downstream accepts the window.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - col, row, win_valid and win_last clear to 0; win_out clears to all zeros.
  - The 5x5 shift registers clear to 0.
  - Line-buffer RAM contents are not cleared; they are don't-care because windows are gated by row/col.
  - Reset mid-frame abandons the frame. The first pixel after reset is treated as (0,0) whether or not pix_sof is asserted.
- Handshake:
  - pix_ready = !win_valid || win_ready (combinational).
  - A pixel is accepted when pix_valid && pix_ready.
  - A window is consumed when win_valid && win_ready.
  - While win_valid && !win_ready: win_out and win_last are held stable and no pixel is accepted.
- Position counters:
  - col counts 0..image_width-1. On acceptance with col = image_width-1, col wraps to 0 and row increments.
  - row counts 0..image_height-1 and wraps to 0 after the last pixel of the frame.
  - Accepted pixel with pix_sof=1: it is treated as (0,0); the counters become col=1, row=0 after it, and previous partial-frame state is discarded logically.
  - pix_sof on a pixel already at (0,0) has no extra effect.
- Line buffers:
  - Four buffers, each image_width deep, addressed by col and chained: LB0 holds row r-1, LB3 holds row r-4.
  - On acceptance, each buffer reads at col before write (read-old, write-new in the same cycle).
  - The incoming pixel is written to LB0; LBi's old value is written to LB(i+1).
- Window registers:
  - Five rows of 5-deep shift registers; each acceptance shifts in the column {LB3, LB2, LB1, LB0, pix_in}.
  - Slot order is row-major from the oldest row and oldest column: slot 0 = (r-4, c-4), slot 4 = (r-4, c), slot 12 = centre (r-2, c-2), slot 20 = (r, c-4), slot 24 = (r, c) = current pixel.
- Output:
  - When the accepted pixel has row ≥ 4 and col ≥ 4, win_out loads the new window and win_valid=1 on the next cycle. Latency is 1 cycle from acceptance.
  - If an acceptance does not complete a window and the current window is consumed, win_valid drops to 0.
  - win_last=1 with the window for (image_height-1, image_width-1), else 0.
- Counts and values:
  - Windows per frame = (image_height-4)*(image_width-4).
  - Windows never span a row wrap: columns 0..3 of every row produce no output.
  - Pixels pass through bit-exact with sign preserved; no arithmetic is performed.
- Simultaneous events: consume and accept in the same cycle give full throughput of 1 window per cycle.
- Frames back-to-back with no bubble are supported.

Test Plan (image_width=8, image_height=6, pixel value = row*16+col unless stated):
1. Full frame, pix_valid=1 and win_ready=1 continuously:
   - First win_valid occurs the cycle after the 37th accepted pixel (4,4), with slot0=0, slot12=34, slot24=68.
   - Exactly 8 windows are produced.
   - The 8th window has win_last=1 and slot24=87.
2. Row wrap: after the window for (4,7) (slot24=71), the next window is for (5,4) (slot0=16, slot24=84), and windows for (5,0)..(5,3) are absent.
3. Backpressure: hold win_ready=0 for 3 cycles while win_valid=1:
   - pix_ready=0 and win_out is stable for those 3 cycles.
   - After release, the sequence resumes with no pixel lost or duplicated (all 8 windows still correct).
4. pix_sof asserted on the pixel at (3,2) mid-frame: that pixel becomes (0,0); no window appears until 36 more pixels are accepted, and subsequent windows match a fresh frame.
5. rst_n=0 for 1 cycle after window 3: win_valid=0 and win_out=0 the next cycle; a new frame then produces 8 correct windows.
6. Signed pass-through: frame with pixel (4,4) = -256 and all others 255 → first window slot24 bits = 9'h100 and all other slots 9'h0FF.

Source files
------------

// File: rtl/conv_window_gen_5x5.sv
// Streaming 5x5 sliding-window generator: four chained line buffers feed a 5x5
// shift-register window that is emitted under valid/ready for valid-mode positions.
module conv_window_gen_5x5 #(
   parameter int unsigned pixel_width  = 9,
   parameter int unsigned image_width  = 516,
   parameter int unsigned image_height = 516,
   parameter int unsigned kernel_size  = 5
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic [pixel_width-1:0]                         pix_in,
   input  logic                                           pix_valid,
   input  logic                                           pix_sof,
   output logic                                           pix_ready,
   output logic [kernel_size*kernel_size*pixel_width-1:0] win_out,
   output logic                                           win_valid,
   output logic                                           win_last,
   input  logic                                           win_ready
);

   localparam int unsigned col_w = $clog2(image_width);
   localparam int unsigned row_w = $clog2(image_height);
   localparam int unsigned lb_n  = kernel_size - 1;
   localparam int unsigned win_w = kernel_size * kernel_size * pixel_width;

   localparam logic [col_w-1:0] col_last = col_w'(image_width - 1);
   localparam logic [row_w-1:0] row_last = row_w'(image_height - 1);
   localparam logic [col_w-1:0] col_win  = col_w'(kernel_size - 1);
   localparam logic [row_w-1:0] row_win  = row_w'(kernel_size - 1);

   logic                   accept;
   logic                   consume;
   logic [col_w-1:0]       col;
   logic [col_w-1:0]       col_eff;
   logic [col_w-1:0]       col_nxt;
   logic [row_w-1:0]       row;
   logic [row_w-1:0]       row_eff;
   logic [row_w-1:0]       row_nxt;
   logic                   win_hit;
   logic                   last_hit;
   logic [pixel_width-1:0] lb [lb_n][image_width];
   logic [pixel_width-1:0] lb_rd [lb_n];
   logic [pixel_width-1:0] new_col [kernel_size];
   logic [pixel_width-1:0] win_reg [kernel_size][kernel_size];
   logic [win_w-1:0]       win_nxt;

   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign consume   = win_valid && win_ready;

   // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
   always_comb begin
      col_eff  = pix_sof ? '0 : col;
      row_eff  = pix_sof ? '0 : row;
      col_nxt  = col_eff + col_w'(1);
      row_nxt  = row_eff;
      if (col_eff == col_last) begin
         col_nxt = '0;
         row_nxt = (row_eff == row_last) ? '0 : row_eff + row_w'(1);
      end
      win_hit  = (row_eff >= row_win) && (col_eff >= col_win);
      last_hit = (row_eff == row_last) && (col_eff == col_last);
   end

   // Column entering the window, oldest row first; buffers are read before being written.
   always_comb begin
      for (int unsigned i = 0; i < lb_n; i++) begin
         lb_rd[i] = lb[i][col_eff];
      end
      for (int unsigned j = 0; j < lb_n; j++) begin
         new_col[j] = lb_rd[lb_n-1-j];
      end
      new_col[kernel_size-1] = pix_in;
   end

   // Window after this acceptance, packed row-major with the newest column in the top slot of each row.
   always_comb begin
      win_nxt = '0;
      for (int unsigned j = 0; j < kernel_size; j++) begin
         for (int unsigned i = 0; i < kernel_size - 1; i++) begin
            win_nxt[(j*kernel_size+i)*pixel_width +: pixel_width] = win_reg[j][i+1];
         end
         win_nxt[(j*kernel_size+kernel_size-1)*pixel_width +: pixel_width] = new_col[j];
      end
   end

   // Line-buffer RAM: no reset, contents are gated out by the position counters.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb[0][col_eff] <= pix_in;
         for (int unsigned i = 1; i < lb_n; i++) begin
            lb[i][col_eff] <= lb_rd[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         win_out   <= '0;
         for (int unsigned j = 0; j < kernel_size; j++) begin
            for (int unsigned i = 0; i < kernel_size; i++) begin
               win_reg[j][i] <= '0;
            end
         end
      end else begin
         if (accept) begin
            col <= col_nxt;
            row <= row_nxt;
            for (int unsigned j = 0; j < kernel_size; j++) begin
               for (int unsigned i = 0; i < kernel_size; i++) begin
                  win_reg[j][i] <= win_nxt[(j*kernel_size+i)*pixel_width +: pixel_width];
               end
            end
         end
         // Acceptance only happens when the held window is absent or being consumed.
         if (accept && win_hit) begin
            win_out   <= win_nxt;
            win_valid <= 1'b1;
            win_last  <= last_hit;
         end else if (consume) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
         end
      end
   end

endmodule
